// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: two-port round-robin arbiter and sequencer in front of
// Data_Memory. Port 0 is the core load/store stage, port 1 the debug/loader.
// Each granted request is latched, driven for ACCESS_CYCLES cycles, then
// acknowledged with a one-cycle pulse on the owning port.
module data_memory_arbiter #(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  output logic [DATA_WIDTH-1:0] Write_Data,
  output logic                  MemWrite,
  output logic                  MemRead,
  input  logic [DATA_WIDTH-1:0] Read_Data
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] ACK    = 2'd2;

  // Counter only has to reach ACCESS_CYCLES-1, so it never wraps in an access.
  localparam int              CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  logic [1:0]            state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  gnt_r;
  logic                  last_grant_r;
  logic                  op_r;

  logic                  grant_valid_s;
  logic                  grant_port_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic                  sel_we_s;

  // Round-robin pick: a tie goes to the port that was not served last.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_port_s  = 1'b0;
    if (req0 && req1) begin
      grant_valid_s = 1'b1;
      grant_port_s  = ~last_grant_r;
    end else if (req0) begin
      grant_valid_s = 1'b1;
      grant_port_s  = 1'b0;
    end else if (req1) begin
      grant_valid_s = 1'b1;
      grant_port_s  = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_port_s  = 1'b0;
    end
  end

  // Request fields of the port about to be granted.
  always_comb begin
    sel_addr_s  = addr0;
    sel_wdata_s = wdata0;
    sel_we_s    = we0;
    if (grant_port_s) begin
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
      sel_we_s    = we1;
    end else begin
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
      sel_we_s    = we0;
    end
  end

  // Sequencer: IDLE grants and latches, ACCESS drives memory, ACK pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      gnt_r        <= 1'b0;
      last_grant_r <= 1'b1;
      op_r         <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
      Mem_Addr     <= '0;
      Write_Data   <= '0;
      MemWrite     <= 1'b0;
      MemRead      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            Mem_Addr     <= sel_addr_s;
            Write_Data   <= sel_wdata_s;
            op_r         <= sel_we_s;
            MemWrite     <= sel_we_s;
            MemRead      <= ~sel_we_s;
            gnt_r        <= grant_port_s;
            last_grant_r <= grant_port_s;
            cnt_r        <= '0;
            state_r      <= ACCESS;
          end else begin
            state_r      <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt_r == CNT_LAST) begin
            // Writes leave the port's read data untouched.
            if (!op_r) begin
              if (gnt_r) begin
                rdata1 <= Read_Data;
              end else begin
                rdata0 <= Read_Data;
              end
            end
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            ack0     <= ~gnt_r;
            ack1     <= gnt_r;
            state_r  <= ACK;
          end else begin
            cnt_r    <= cnt_r + 1'b1;
          end
        end
        ACK: begin
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ack0     <= 1'b0;
          ack1     <= 1'b0;
          MemRead  <= 1'b0;
          MemWrite <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: one instance with single-cycle
// access backed by a small memory model, one with three wait states.
`timescale 1ns/1ps
module tb_data_memory_arbiter;

  logic        clk;
  logic        reset;

  // Instance with ACCESS_CYCLES = 1
  logic        req0, req1, we0, we1;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, MemWrite, MemRead;
  logic [63:0] rdata0, rdata1, Mem_Addr, Write_Data, Read_Data;

  // Instance with ACCESS_CYCLES = 3
  logic        q_req0, q_req1, q_we0, q_we1;
  logic [63:0] q_addr0, q_addr1, q_wdata0, q_wdata1;
  logic        q_ack0, q_ack1, q_MemWrite, q_MemRead;
  logic [63:0] q_rdata0, q_rdata1, q_Mem_Addr, q_Write_Data, q_Read_Data;

  logic [63:0] mem [16];

  int n_tests = 0;
  int n_fail  = 0;

  data_memory_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ACCESS_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .Mem_Addr(Mem_Addr), .Write_Data(Write_Data),
    .MemWrite(MemWrite), .MemRead(MemRead), .Read_Data(Read_Data)
  );

  data_memory_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ACCESS_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0(q_req0), .req1(q_req1), .we0(q_we0), .we1(q_we1),
    .addr0(q_addr0), .addr1(q_addr1), .wdata0(q_wdata0), .wdata1(q_wdata1),
    .ack0(q_ack0), .ack1(q_ack1), .rdata0(q_rdata0), .rdata1(q_rdata1),
    .Mem_Addr(q_Mem_Addr), .Write_Data(q_Write_Data),
    .MemWrite(q_MemWrite), .MemRead(q_MemRead), .Read_Data(q_Read_Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word index is Mem_Addr[6:3]; preloaded while reset is low.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 64'hA5A5_0000_0000_0000 | 64'(i);
    end else if (MemWrite) begin
      mem[Mem_Addr[6:3]] <= Write_Data;
    end
  end
  assign Read_Data   = mem[Mem_Addr[6:3]];
  assign q_Read_Data = 64'hC0DE_0000_0000_0000 | q_Mem_Addr;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int mr_cnt, mw_cnt, ack_cnt, ack_at, n_gr;
  logic overlap, both_ops;
  logic order [4];

  initial begin
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 64'd0; addr1 = 64'd0; wdata0 = 64'd0; wdata1 = 64'd0;
    q_req0 = 1'b0; q_req1 = 1'b0; q_we0 = 1'b0; q_we1 = 1'b0;
    q_addr0 = 64'd0; q_addr1 = 64'd0; q_wdata0 = 64'd0; q_wdata1 = 64'd0;

    // Reset state
    tick(); tick(); tick();
    check("rst_ack0", 64'(ack0), 64'd0);
    check("rst_ack1", 64'(ack1), 64'd0);
    check("rst_memread", 64'(MemRead), 64'd0);
    check("rst_memwrite", 64'(MemWrite), 64'd0);
    check("rst_mem_addr", Mem_Addr, 64'd0);
    check("rst_rdata0", rdata0, 64'd0);
    reset = 1'b1;

    // Single write then read on port 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 64'd8; wdata0 = 64'hDEAD_BEEF;
    tick();
    check("wr_memwrite", 64'(MemWrite), 64'd1);
    check("wr_memread", 64'(MemRead), 64'd0);
    check("wr_mem_addr", Mem_Addr, 64'd8);
    check("wr_write_data", Write_Data, 64'hDEAD_BEEF);
    check("wr_no_early_ack", 64'(ack0), 64'd0);
    tick();
    check("wr_memwrite_drop", 64'(MemWrite), 64'd0);
    check("wr_ack0", 64'(ack0), 64'd1);
    check("wr_rdata0_kept", rdata0, 64'd0);
    req0 = 1'b0;
    tick();
    check("wr_ack0_clear", 64'(ack0), 64'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd8;
    tick();
    check("rd_memread", 64'(MemRead), 64'd1);
    check("rd_memwrite", 64'(MemWrite), 64'd0);
    tick();
    check("rd_ack0", 64'(ack0), 64'd1);
    check("rd_rdata0", rdata0, 64'hDEAD_BEEF);
    req0 = 1'b0;
    tick();
    check("rd_ack0_clear", 64'(ack0), 64'd0);

    // Input stability: addr1 moves during ACCESS
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'd16;
    tick();
    check("stab_memread", 64'(MemRead), 64'd1);
    addr1 = 64'd24;
    #1;
    check("stab_addr_access", Mem_Addr, 64'd16);
    tick();
    check("stab_ack1", 64'(ack1), 64'd1);
    check("stab_rdata1", rdata1, 64'hA5A5_0000_0000_0002);
    check("stab_addr_hold", Mem_Addr, 64'd16);
    check("stab_ack0_quiet", 64'(ack0), 64'd0);
    req1 = 1'b0;
    tick();
    check("stab_ack1_clear", 64'(ack1), 64'd0);

    // Back-to-back: req1 held across ack1
    req1 = 1'b1; addr1 = 64'd48;
    tick();
    tick();
    check("b2b_ack1_first", 64'(ack1), 64'd1);
    check("b2b_rdata1_first", rdata1, 64'hA5A5_0000_0000_0006);
    addr1 = 64'd56;
    tick();
    check("b2b_ack1_gap", 64'(ack1), 64'd0);
    check("b2b_memread_gap", 64'(MemRead), 64'd0);
    tick();
    check("b2b_memread_e3", 64'(MemRead), 64'd1);
    check("b2b_addr_e3", Mem_Addr, 64'd56);
    check("b2b_rdata1_hold", rdata1, 64'hA5A5_0000_0000_0006);
    tick();
    check("b2b_ack1_second", 64'(ack1), 64'd1);
    check("b2b_rdata1_second", rdata1, 64'hA5A5_0000_0000_0007);
    req1 = 1'b0;
    tick();

    // Wait states on the three-cycle instance
    q_req0 = 1'b1; q_we0 = 1'b0; q_addr0 = 64'd0;
    mr_cnt = 0; mw_cnt = 0; ack_cnt = 0; ack_at = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (q_MemRead)  mr_cnt++;
      if (q_MemWrite) mw_cnt++;
      if (q_ack0) begin
        ack_cnt++;
        ack_at = k;
        q_req0 = 1'b0;
      end
    end
    check("ws_memread_cycles", 64'(mr_cnt), 64'd3);
    check("ws_memwrite_cycles", 64'(mw_cnt), 64'd0);
    check("ws_ack_cycle", 64'(ack_at), 64'd4);
    check("ws_ack_count", 64'(ack_cnt), 64'd1);
    check("ws_rdata0", q_rdata0, 64'hC0DE_0000_0000_0000);

    // Reset in the middle of an access
    req1 = 1'b1; we1 = 1'b1; addr1 = 64'd0; wdata1 = 64'h1234;
    tick();
    check("mid_pre_memwrite", 64'(MemWrite), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_memwrite", 64'(MemWrite), 64'd0);
    check("mid_memread", 64'(MemRead), 64'd0);
    check("mid_ack0", 64'(ack0), 64'd0);
    check("mid_ack1", 64'(ack1), 64'd0);
    req1 = 1'b0;
    tick(); tick();
    reset = 1'b1;

    // Contention: both ports request for four grants
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 64'd32; addr1 = 64'd40;
    n_gr = 0; overlap = 1'b0; both_ops = 1'b0;
    for (int c = 0; c < 40 && n_gr < 4; c++) begin
      tick();
      if (ack0 && ack1)        overlap  = 1'b1;
      if (MemRead && MemWrite) both_ops = 1'b1;
      if (ack0) begin
        order[n_gr] = 1'b0;
        n_gr++;
      end else if (ack1) begin
        order[n_gr] = 1'b1;
        n_gr++;
      end
      if (n_gr == 4) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    check("cont_grants", 64'(n_gr), 64'd4);
    check("cont_order0", 64'(order[0]), 64'd0);
    check("cont_order1", 64'(order[1]), 64'd1);
    check("cont_order2", 64'(order[2]), 64'd0);
    check("cont_order3", 64'(order[3]), 64'd1);
    check("cont_ack_overlap", 64'(overlap), 64'd0);
    check("cont_rw_overlap", 64'(both_ops), 64'd0);
    check("cont_rdata0", rdata0, 64'hA5A5_0000_0000_0004);
    check("cont_rdata1", rdata1, 64'hA5A5_0000_0000_0005);
    tick(); tick();
    check("cont_idle_memread", 64'(MemRead), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
